// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, grant owner
// and the fetch/data tie-break rule.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IF,
        ARB_DM,
        ARB_ERR
    } arb_state_t;

    typedef enum logic {
        GRANT_IF,
        GRANT_DM
    } grant_t;

    // Data stage wins a contest unless it also won the previous one
    function automatic grant_t pick_grant(input logic if_pend, input logic dm_pend,
                                          input grant_t last_grant);
        if (if_pend && dm_pend)
            return (last_grant == GRANT_DM) ? GRANT_IF : GRANT_DM;
        return dm_pend ? GRANT_DM : GRANT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Saturating wait-cycle counter; expired flags the last wait cycle allowed
// before the access is declared dead.
module mem_port_arbiter_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != CNT_W'(TIMEOUT)))
            count <= count + CNT_W'(1);
    end

    assign expired = (count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (read-only) and the data
// stage, holding the registered memory request until mem_ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              stall_fetch,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_timeout
);

    arb_state_t state;
    arb_state_t state_next;
    grant_t     last_grant;
    grant_t     grant_c;
    logic       start_c;
    logic       busy_c;
    logic       expired;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ARB_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        grant_c    = pick_grant(if_req, dm_req, last_grant);
        case (state)
            ARB_IDLE: begin
                if (if_req || dm_req) begin
                    start_c    = 1'b1;
                    state_next = (grant_c == GRANT_DM) ? ARB_DM : ARB_IF;
                end
            end
            ARB_IF, ARB_DM: begin
                if (mem_ready)
                    state_next = ARB_IDLE;
                else if (expired)
                    state_next = ARB_ERR;
            end
            ARB_ERR:  state_next = ARB_ERR;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // Outputs: completion and read data pass straight through from memory
    always_comb begin
        busy_c      = (state == ARB_IF) || (state == ARB_DM);
        if_done     = (state == ARB_IF) && mem_ready;
        dm_done     = (state == ARB_DM) && mem_ready;
        if_rdata    = rst ? '0 : mem_rdata;
        dm_rdata    = rst ? '0 : mem_rdata;
        stall_fetch = if_req && !if_done && !rst;
        stall_dm    = dm_req && !dm_done && !rst;
    end

    // Memory-side request registers, held stable for the whole access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            last_grant  <= GRANT_IF;
            err_timeout <= 1'b0;
        end else begin
            if (start_c) begin
                mem_req    <= 1'b1;
                last_grant <= grant_c;
                if (grant_c == GRANT_DM) begin
                    mem_we    <= dm_we;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                end
            end else if (busy_c && (mem_ready || expired)) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (busy_c && !mem_ready && expired)
                err_timeout <= 1'b1;
        end
    end

    mem_port_arbiter_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy_c || mem_ready),
        .enable  (busy_c && !mem_ready),
        .expired (expired)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand
// sequences for timeout and asynchronous reset mid-access.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        stall_fetch;
    logic        stall_dm;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_done     (dm_done),
        .stall_fetch (stall_fetch),
        .stall_dm    (stall_dm),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_if_done;
        logic        e_dm_done;
    } vec_t;

    localparam int unsigned NVEC = 17;
    vec_t vecs [NVEC];

    localparam logic [31:0] IA0 = 32'h0040_0000;
    localparam logic [31:0] IA1 = 32'h0040_0004;
    localparam logic [31:0] DA0 = 32'h1001_0000;
    localparam logic [31:0] DA1 = 32'h1001_0008;
    localparam logic [31:0] DS  = 32'h1001_0004;
    localparam logic [31:0] WD  = 32'hDEAD_BEEF;

    function automatic vec_t v(input logic r, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic mr, input logic [31:0] md,
                               input logic er, input logic ew, input logic [31:0] ea,
                               input logic [31:0] ewd, input logic eid, input logic edd);
        vec_t t;
        t.rst = r;   t.if_req = ir; t.if_addr = ia;
        t.dm_req = dr; t.dm_we = dw; t.dm_addr = da; t.dm_wdata = dwd;
        t.mem_ready = mr; t.mem_rdata = md;
        t.e_req = er; t.e_we = ew; t.e_addr = ea; t.e_wdata = ewd;
        t.e_if_done = eid; t.e_dm_done = edd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_req"},     32'(mem_req),     32'h0);
        chk({tag, " mem_we"},      32'(mem_we),      32'h0);
        chk({tag, " mem_addr"},    mem_addr,         32'h0);
        chk({tag, " mem_wdata"},   mem_wdata,        32'h0);
        chk({tag, " if_done"},     32'(if_done),     32'h0);
        chk({tag, " dm_done"},     32'(dm_done),     32'h0);
        chk({tag, " stall_fetch"}, 32'(stall_fetch), 32'h0);
        chk({tag, " stall_dm"},    32'(stall_dm),    32'h0);
        chk({tag, " err_timeout"}, 32'(err_timeout), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fetch-only with two wait cycles, reset, contest from reset, store
        vecs[0]  = v(0, 1, IA0, 0, 0, 0,   0,  0, 32'h0,         0, 0, 0,   0,  0, 0);
        vecs[1]  = v(0, 1, IA0, 0, 0, 0,   0,  0, 32'h0,         1, 0, IA0, 0,  0, 0);
        vecs[2]  = v(0, 1, IA0, 0, 0, 0,   0,  0, 32'h0,         1, 0, IA0, 0,  0, 0);
        vecs[3]  = v(0, 1, IA0, 0, 0, 0,   0,  1, 32'h2008_0005, 1, 0, IA0, 0,  1, 0);
        vecs[4]  = v(0, 0, 0,   0, 0, 0,   0,  0, 32'h0,         0, 0, 0,   0,  0, 0);
        vecs[5]  = v(1, 0, 0,   0, 0, 0,   0,  0, 32'h0,         0, 0, 0,   0,  0, 0);
        vecs[6]  = v(0, 1, IA1, 1, 0, DA0, 0,  0, 32'h0,         0, 0, 0,   0,  0, 0);
        vecs[7]  = v(0, 1, IA1, 1, 0, DA0, 0,  1, 32'h1111_2222, 1, 0, DA0, 0,  0, 1);
        vecs[8]  = v(0, 1, IA1, 1, 0, DA1, 0,  1, 32'h7777_8888, 0, 0, 0,   0,  0, 0);
        vecs[9]  = v(0, 1, IA1, 1, 0, DA1, 0,  1, 32'h3333_4444, 1, 0, IA1, 0,  1, 0);
        vecs[10] = v(0, 0, 0,   1, 0, DA1, 0,  0, 32'h0,         0, 0, 0,   0,  0, 0);
        vecs[11] = v(0, 0, 0,   1, 0, DA1, 0,  1, 32'h5555_6666, 1, 0, DA1, 0,  0, 1);
        vecs[12] = v(0, 0, 0,   1, 1, DS,  WD, 0, 32'h0,         0, 0, 0,   0,  0, 0);
        vecs[13] = v(0, 0, 0,   1, 1, DS,  WD, 0, 32'h0,         1, 1, DS,  WD, 0, 0);
        vecs[14] = v(0, 0, 0,   1, 1, DS,  WD, 1, 32'h0BAD_F00D, 1, 1, DS,  WD, 0, 1);
        vecs[15] = v(0, 0, 0,   0, 0, 0,   0,  0, 32'h0,         0, 0, 0,   0,  0, 0);
        vecs[16] = v(0, 0, 0,   0, 0, 0,   0,  0, 32'h0,         0, 0, 0,   0,  0, 0);

        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < int'(NVEC); i++) begin
            tick();
            rst       = vecs[i].rst;
            if_req    = vecs[i].if_req;
            if_addr   = vecs[i].if_addr;
            dm_req    = vecs[i].dm_req;
            dm_we     = vecs[i].dm_we;
            dm_addr   = vecs[i].dm_addr;
            dm_wdata  = vecs[i].dm_wdata;
            mem_ready = vecs[i].mem_ready;
            mem_rdata = vecs[i].mem_rdata;
            #1;
            chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            chk($sformatf("row%0d mem_we", i),  32'(mem_we),  32'(vecs[i].e_we));
            chk($sformatf("row%0d if_done", i), 32'(if_done), 32'(vecs[i].e_if_done));
            chk($sformatf("row%0d dm_done", i), 32'(dm_done), 32'(vecs[i].e_dm_done));
            chk($sformatf("row%0d stall_fetch", i), 32'(stall_fetch),
                32'(vecs[i].if_req && !vecs[i].e_if_done && !vecs[i].rst));
            chk($sformatf("row%0d stall_dm", i), 32'(stall_dm),
                32'(vecs[i].dm_req && !vecs[i].e_dm_done && !vecs[i].rst));
            chk($sformatf("row%0d err_timeout", i), 32'(err_timeout), 32'h0);
            if (vecs[i].e_req)
                chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            if (vecs[i].e_we)
                chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            if (vecs[i].e_if_done)
                chk($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].mem_rdata);
            if (vecs[i].e_dm_done)
                chk($sformatf("row%0d dm_rdata", i), dm_rdata, vecs[i].mem_rdata);
        end

        // Timeout: memory never answers a fetch
        tick();
        if_req = 1'b1; if_addr = IA0; mem_ready = 1'b0;
        #1;
        chk("to idle mem_req", 32'(mem_req), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("to busy%0d mem_req", k), 32'(mem_req), 32'h1);
            chk($sformatf("to busy%0d if_done", k), 32'(if_done), 32'h0);
        end
        tick();
        chk("to err mem_req",     32'(mem_req),     32'h0);
        chk("to err err_timeout", 32'(err_timeout), 32'h1);
        chk("to err if_done",     32'(if_done),     32'h0);
        chk("to err stall_fetch", 32'(stall_fetch), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            mem_ready = 1'b1; dm_req = 1'b1; dm_addr = DA0;
            #1;
            chk($sformatf("err%0d if_done", k),     32'(if_done),     32'h0);
            chk($sformatf("err%0d dm_done", k),     32'(dm_done),     32'h0);
            chk($sformatf("err%0d mem_req", k),     32'(mem_req),     32'h0);
            chk($sformatf("err%0d err_timeout", k), 32'(err_timeout), 32'h1);
            chk($sformatf("err%0d stall_fetch", k), 32'(stall_fetch), 32'h1);
            chk($sformatf("err%0d stall_dm", k),    32'(stall_dm),    32'h1);
        end
        rst = 1'b1;
        #1;
        chk_all_zero("err reset");
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        rst = 1'b0;

        // Reset mid-access aborts the data access; dm wins the next contest
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = DA0;
        #1;
        tick();
        chk("mid busy mem_req",  32'(mem_req), 32'h1);
        chk("mid busy mem_addr", mem_addr,     DA0);
        if_req = 1'b1; if_addr = IA1;
        #1;
        rst = 1'b1;
        #1;
        chk("mid rst mem_req", 32'(mem_req), 32'h0);
        chk("mid rst dm_done", 32'(dm_done), 32'h0);
        #2;
        rst = 1'b0;
        tick();
        chk("mid regrant mem_req",  32'(mem_req), 32'h1);
        chk("mid regrant mem_addr", mem_addr,     DA0);
        chk("mid regrant mem_we",   32'(mem_we),  32'h0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        chk("mid regrant dm_done",  32'(dm_done), 32'h1);
        chk("mid regrant if_done",  32'(if_done), 32'h0);
        chk("mid regrant dm_rdata", dm_rdata,     32'hCAFE_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
